// File: rtl/uart_receptor_jogo_if.sv
// Status bus carried out of the game-link UART receiver.
//
// Signals:
//   estado, macro, micro        - 4-bit fields of the last complete status word
//   resultado_macro, resultado_jogo - 2-bit result fields of the same word
//   valid                       - one-cycle pulse on the edge the fields update
//   erro                        - one-cycle pulse on a dropped character/word
//
// Handshake: valid is a strobe, not a request. There is no ready; the
// consumer must capture the fields on the cycle valid is high (they also
// stay stable until the next word). erro never coincides with valid.
//
// Modports: master = receiver (drives everything), slave = consumer.
interface uart_receptor_jogo_if;
  logic [3:0] estado;
  logic [3:0] macro;
  logic [3:0] micro;
  logic [1:0] resultado_macro;
  logic [1:0] resultado_jogo;
  logic       valid;
  logic       erro;

  modport master (
    output estado, macro, micro, resultado_macro, resultado_jogo, valid, erro
  );

  modport slave (
    input estado, macro, micro, resultado_macro, resultado_jogo, valid, erro
  );
endinterface

// File: rtl/uart_receptor_jogo.sv
// UART receiver for the game status link.
//
// Receives 8N1 characters (LSB first) on s_in and assembles pairs of them,
// high byte first, into a 16-bit status word
//   {estado, macro, micro, resultado_macro, resultado_jogo}.
// byte0 = {estado, macro}, byte1 = {micro, resultado_macro, resultado_jogo}.
//
// Ports:
//   clock      - system clock, rising edge
//   reset      - asynchronous, active-low
//   s_in       - serial line, idle high, asynchronous to clock
//   status     - status bus (see uart_receptor_jogo_if), master side
//   bit_state  - current character FSM state (0 OCIOSO, 1 INICIO, 2 DADOS, 3 PARADA)
//   word_state - current word FSM state (0 ESPERA_ALTO, 1 ESPERA_BAIXO)
//
// Parameters:
//   CLKS_PER_BIT - clock cycles per serial bit (>= 2)
//   TIMEOUT_BITS - inter-byte timeout in bit times (>= 1)
//
// Optional feature: define JOGAO_RX_TIMEOUT_EN to drop a stored high byte
// (with an erro pulse) when no start edge follows it within
// TIMEOUT_BITS*CLKS_PER_BIT cycles of its stop sample. Without the macro the
// receiver waits for the low byte indefinitely.
module uart_receptor_jogo #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       s_in,
  uart_receptor_jogo_if.master       status,
  output logic [1:0]                 bit_state,
  output logic                       word_state
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

  generate
    if (CLKS_PER_BIT < 2 || TIMEOUT_BITS < 1) begin : g_bad_params
      $error("uart_receptor_jogo: CLKS_PER_BIT must be >= 2 and TIMEOUT_BITS >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    INICIO = 2'd1,
    DADOS  = 2'd2,
    PARADA = 2'd3
  } bit_state_t;

  typedef enum logic {
    ESPERA_ALTO  = 1'b0,
    ESPERA_BAIXO = 1'b1
  } word_state_t;

  // ---------------------------------------------------------------------
  // Input synchronizer plus one extra stage for falling-edge detection.
  // All three reset to 1 so a line held idle never looks like a start.
  // ---------------------------------------------------------------------
  logic s_meta;
  logic s_sync;
  logic s_prev;
  logic fall;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s_meta <= 1'b1;
      s_sync <= 1'b1;
      s_prev <= 1'b1;
    end else begin
      s_meta <= s_in;
      s_sync <= s_meta;
      s_prev <= s_sync;
    end
  end

  assign fall = s_prev & ~s_sync;

  // ---------------------------------------------------------------------
  // Character FSM. byte_ok / byte_err are one-cycle pulses issued on the
  // edge of the stop-bit sample; rx_shift holds the byte from then until
  // the next character's first data sample.
  // ---------------------------------------------------------------------
  bit_state_t    bit_st;
  logic [CW-1:0] bit_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    rx_shift;
  logic          byte_ok;
  logic          byte_err;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bit_st   <= OCIOSO;
      bit_cnt  <= '0;
      bit_idx  <= '0;
      rx_shift <= '0;
      byte_ok  <= 1'b0;
      byte_err <= 1'b0;
    end else begin
      byte_ok  <= 1'b0;
      byte_err <= 1'b0;
      case (bit_st)
        OCIOSO: begin
          // A fall coinciding with the PARADA sample happened while we were
          // still in PARADA, so it is never seen here: s_prev is already low.
          if (fall) begin
            bit_st  <= INICIO;
            bit_cnt <= '0;
            bit_idx <= '0;
          end
        end
        INICIO: begin
          // Mid-start-bit check; a line already back high was a glitch.
          if (bit_cnt == HALF_M1) begin
            bit_cnt <= '0;
            bit_st  <= s_sync ? OCIOSO : DADOS;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        DADOS: begin
          if (bit_cnt == FULL_M1) begin
            bit_cnt  <= '0;
            // LSB arrives first, so shift in at the top and move down.
            rx_shift <= {s_sync, rx_shift[7:1]};
            if (bit_idx == 3'd7) begin
              bit_st <= PARADA;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        PARADA: begin
          if (bit_cnt == FULL_M1) begin
            bit_cnt <= '0;
            if (s_sync) begin
              byte_ok <= 1'b1;
            end else begin
              byte_err <= 1'b1;
            end
            bit_st <= OCIOSO;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: begin
          bit_st <= OCIOSO;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Word FSM and registered status outputs. Acting on the byte pulses one
  // cycle after the stop sample puts valid and the field update on the
  // same edge.
  // ---------------------------------------------------------------------
  word_state_t word_st;
  logic [7:0]  hi_byte;
  logic [3:0]  estado_r;
  logic [3:0]  macro_r;
  logic [3:0]  micro_r;
  logic [1:0]  res_macro_r;
  logic [1:0]  res_jogo_r;
  logic        valid_r;
  logic        erro_r;

`ifdef JOGAO_RX_TIMEOUT_EN
  localparam int TMO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW = $clog2(TMO_LIMIT + 1);
  // The timer starts counting one cycle after the stop sample, so firing
  // at LIMIT-2 lands erro exactly LIMIT cycles after that sample.
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_LIMIT - 2);
  logic [TW-1:0] tmo_cnt;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      word_st     <= ESPERA_ALTO;
      hi_byte     <= '0;
      estado_r    <= '0;
      macro_r     <= '0;
      micro_r     <= '0;
      res_macro_r <= '0;
      res_jogo_r  <= '0;
      valid_r     <= 1'b0;
      erro_r      <= 1'b0;
`ifdef JOGAO_RX_TIMEOUT_EN
      tmo_cnt     <= '0;
`endif
    end else begin
      valid_r <= 1'b0;
      erro_r  <= 1'b0;
      if (byte_ok) begin
        if (word_st == ESPERA_ALTO) begin
          hi_byte <= rx_shift;
          word_st <= ESPERA_BAIXO;
`ifdef JOGAO_RX_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
        end else begin
          estado_r    <= hi_byte[7:4];
          macro_r     <= hi_byte[3:0];
          micro_r     <= rx_shift[7:4];
          res_macro_r <= rx_shift[3:2];
          res_jogo_r  <= rx_shift[1:0];
          valid_r     <= 1'b1;
          word_st     <= ESPERA_ALTO;
        end
      end else if (byte_err) begin
        // A bad character also invalidates any half-received word.
        erro_r  <= 1'b1;
        hi_byte <= '0;
        word_st <= ESPERA_ALTO;
      end
`ifdef JOGAO_RX_TIMEOUT_EN
      else if (word_st == ESPERA_BAIXO && bit_st == OCIOSO && !fall) begin
        // Timer only runs while the line is quiet; a detected start edge
        // freezes it until that character resolves.
        if (tmo_cnt == TMO_LAST) begin
          erro_r  <= 1'b1;
          hi_byte <= '0;
          word_st <= ESPERA_ALTO;
        end else begin
          tmo_cnt <= tmo_cnt + 1'b1;
        end
      end
`endif
    end
  end

  assign status.estado          = estado_r;
  assign status.macro           = macro_r;
  assign status.micro           = micro_r;
  assign status.resultado_macro = res_macro_r;
  assign status.resultado_jogo  = res_jogo_r;
  assign status.valid           = valid_r;
  assign status.erro            = erro_r;

  assign bit_state  = bit_st;
  assign word_state = word_st;

endmodule

// File: tb/tb_uart_receptor_jogo.sv
// Self-checking bench for uart_receptor_jogo (CLKS_PER_BIT=8, TIMEOUT_BITS=20).
// Build with or without JOGAO_RX_TIMEOUT_EN; the timeout section adapts.
module tb_uart_receptor_jogo;

  localparam int CPB = 8;
  localparam int TOB = 20;

  // ---------------- clock / reset ----------------
  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       s_in  = 1'b1;
  logic [1:0] bit_state;
  logic       word_state;

  always #5 clock = ~clock;

  uart_receptor_jogo_if status_if ();

  uart_receptor_jogo #(
    .CLKS_PER_BIT (CPB),
    .TIMEOUT_BITS (TOB)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .s_in       (s_in),
    .status     (status_if),
    .bit_state  (bit_state),
    .word_state (word_state)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int n_valid  = 0;
  int n_erro   = 0;
  int cyc      = 0;
  int erro_cyc = 0;
  logic valid_prev = 1'b0;
  logic erro_prev  = 1'b0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_w;

  typedef struct {
    logic [7:0] b0;
    logic [7:0] b1;
    logic [3:0] estado;
    logic [3:0] macro;
    logic [3:0] micro;
    logic [1:0] rm;
    logic [1:0] rj;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clock) begin
    cyc++;
    if (status_if.valid === 1'b1) begin
      n_valid++;
      check("valid_width", {31'd0, valid_prev}, 32'd0);
      if (exp_q.size() == 0) begin
        check("valid_unexpected", {31'd0, status_if.valid}, 32'd0);
      end else begin
        exp_w = exp_q.pop_front();
        check("word", {16'd0, status_if.estado, status_if.macro, status_if.micro,
                       status_if.resultado_macro, status_if.resultado_jogo}, {16'd0, exp_w});
      end
    end
    if (status_if.erro === 1'b1) begin
      n_erro++;
      erro_cyc = cyc;
      check("erro_width", {31'd0, erro_prev}, 32'd0);
    end
    valid_prev = status_if.valid;
    erro_prev  = status_if.erro;
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(posedge clock);
    s_in = 1'b0;
    repeat (CPB) @(posedge clock);
    for (int i = 0; i < 8; i++) begin
      s_in = b[i];
      repeat (CPB) @(posedge clock);
    end
    s_in = stop;
    repeat (CPB) @(posedge clock);
    s_in = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
  endtask

  task automatic push_exp(input int idx);
    exp_q.push_back({vecs[idx].estado, vecs[idx].macro, vecs[idx].micro,
                     vecs[idx].rm, vecs[idx].rj});
  endtask

  task automatic check_fields(input string tag, input int idx);
    check({tag, "_estado"}, {28'd0, status_if.estado}, {28'd0, vecs[idx].estado});
    check({tag, "_macro"},  {28'd0, status_if.macro},  {28'd0, vecs[idx].macro});
    check({tag, "_micro"},  {28'd0, status_if.micro},  {28'd0, vecs[idx].micro});
    check({tag, "_res_macro"}, {30'd0, status_if.resultado_macro}, {30'd0, vecs[idx].rm});
    check({tag, "_res_jogo"},  {30'd0, status_if.resultado_jogo},  {30'd0, vecs[idx].rj});
  endtask

  task automatic run_word(input int idx);
    int bv;
    int be;
    bv = n_valid;
    be = n_erro;
    push_exp(idx);
    send_byte(vecs[idx].b0, 1'b1);
    idle(2);
    send_byte(vecs[idx].b1, 1'b1);
    idle(4);
    @(negedge clock);
    check("word_valid_count", n_valid, bv + 1);
    check("word_erro_count", n_erro, be);
    check_fields("word", idx);
    idle(20);
    @(negedge clock);
    check_fields("hold", idx);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got %0d checks", n_checks);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int bv;
    int be;
    int t0;

    vecs[0] = '{8'h5A, 8'h3B, 4'h5, 4'hA, 4'h3, 2'd2, 2'd3};
    vecs[1] = '{8'h12, 8'h34, 4'h1, 4'h2, 4'h3, 2'd1, 2'd0};
    vecs[2] = '{8'h00, 8'h0F, 4'h0, 4'h0, 4'h0, 2'd3, 2'd3};
    vecs[3] = '{8'hFF, 8'hFF, 4'hF, 4'hF, 4'hF, 2'd3, 2'd3};
    vecs[4] = '{8'hA5, 8'hC3, 4'hA, 4'h5, 4'hC, 2'd0, 2'd3};
    vecs[5] = '{8'h00, 8'h00, 4'h0, 4'h0, 4'h0, 2'd0, 2'd0};
    vecs[6] = '{8'h81, 8'h42, 4'h8, 4'h1, 4'h4, 2'd0, 2'd2};

    // Reset state
    idle(4);
    @(negedge clock);
    check("rst_valid", {31'd0, status_if.valid}, 32'd0);
    check("rst_erro", {31'd0, status_if.erro}, 32'd0);
    check_fields("rst", 5);
    check("rst_bit_state", {30'd0, bit_state}, 32'd0);
    check("rst_word_state", {31'd0, word_state}, 32'd0);
    reset = 1'b1;
    idle(3);

    // Basic word
    run_word(0);

    // Framing error in ESPERA_ALTO, then a good word
    bv = n_valid;
    be = n_erro;
    send_byte(8'hFF, 1'b0);
    idle(4);
    @(negedge clock);
    check("ferr_erro_count", n_erro, be + 1);
    check("ferr_valid_count", n_valid, bv);
    run_word(1);

    // Framing error on the low byte drops the stored high byte
    bv = n_valid;
    be = n_erro;
    send_byte(8'h77, 1'b1);
    idle(2);
    send_byte(8'h55, 1'b0);
    idle(4);
    @(negedge clock);
    check("ferr2_erro_count", n_erro, be + 1);
    check("ferr2_valid_count", n_valid, bv);
    check("ferr2_word_state", {31'd0, word_state}, 32'd0);
    run_word(1);

    // Short glitch on the line
    bv = n_valid;
    be = n_erro;
    @(posedge clock);
    s_in = 1'b0;
    idle(2);
    s_in = 1'b1;
    idle(20);
    @(negedge clock);
    check("glitch_valid_count", n_valid, bv);
    check("glitch_erro_count", n_erro, be);
    check("glitch_bit_state", {30'd0, bit_state}, 32'd0);

    // Reset in the middle of byte1
    send_byte(8'hC7, 1'b1);
    idle(2);
    @(posedge clock);
    s_in = 1'b0;
    idle(CPB);
    for (int i = 0; i < 3; i++) begin
      s_in = i[0];
      idle(CPB);
    end
    @(negedge clock);
    reset = 1'b0;
    s_in  = 1'b1;
    @(negedge clock);
    check("midrst_valid", {31'd0, status_if.valid}, 32'd0);
    check("midrst_erro", {31'd0, status_if.erro}, 32'd0);
    check_fields("midrst", 5);
    check("midrst_bit_state", {30'd0, bit_state}, 32'd0);
    check("midrst_word_state", {31'd0, word_state}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    idle(5);
    run_word(2);

    // Table sweep
    for (int k = 3; k < 6; k++) begin
      run_word(k);
    end

    // Inter-byte idle
    bv = n_valid;
    be = n_erro;
    send_byte(8'hAB, 1'b1);
    t0 = cyc;
    idle(200);
    @(negedge clock);
`ifdef JOGAO_RX_TIMEOUT_EN
    check("tmo_erro_count", n_erro, be + 1);
    check("tmo_valid_count", n_valid, bv);
    check("tmo_timing_ok", {31'd0, ((erro_cyc - t0) >= 150 && (erro_cyc - t0) <= 170)}, 32'd1);
    check("tmo_word_state", {31'd0, word_state}, 32'd0);
    run_word(6);
`else
    check("notmo_erro_count", n_erro, be);
    check("notmo_valid_count", n_valid, bv);
    check("notmo_word_state", {31'd0, word_state}, 32'd1);
    exp_q.push_back({4'hA, 4'hB, 4'h8, 2'd0, 2'd1});
    send_byte(8'h81, 1'b1);
    idle(4);
    @(negedge clock);
    check("notmo_word_valid", n_valid, bv + 1);
    check("notmo_estado", {28'd0, status_if.estado}, 32'hA);
    check("notmo_macro", {28'd0, status_if.macro}, 32'hB);
    check("notmo_micro", {28'd0, status_if.micro}, 32'h8);
    check("notmo_res_macro", {30'd0, status_if.resultado_macro}, 32'd0);
    check("notmo_res_jogo", {30'd0, status_if.resultado_jogo}, 32'd1);
`endif

    idle(5);
    @(negedge clock);
    check("exp_q_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_receptor_jogo.md
UART_RECEPTOR_JOGO -- requirements
Module: uart_receptor_jogo

Interface
REQ-001 Parameter CLKS_PER_BIT, default 5208, SHALL set clock cycles per serial bit (50 MHz / 9600 baud).
REQ-002 Parameter TIMEOUT_BITS, default 20, SHALL set the inter-byte timeout in bit times (used only under REQ-024).
REQ-003 clock  input  1  system clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 s_in  input  1  serial line, idle high, asynchronous to clock.
REQ-006 estado  output  4  received game FSM state field.
REQ-007 macro  output  4  received macro-board position field.
REQ-008 micro  output  4  received micro-board position field.
REQ-009 resultado_macro  output  2  received macro result field.
REQ-010 resultado_jogo  output  2  received game result field.
REQ-011 valid  output  1  one-cycle pulse when all field outputs update.
REQ-012 erro  output  1  one-cycle pulse on framing error or discarded partial word.

Function
REQ-013 Character format SHALL be 8N1, LSB first: 1 start (0), 8 data, 1 stop (1).
REQ-014 A 16-bit status word {estado, macro, micro, resultado_macro, resultado_jogo} SHALL be carried as two characters, high byte first: byte0 = {estado, macro}, byte1 = {micro, resultado_macro, resultado_jogo}.
REQ-015 s_in SHALL pass through a 2-flop synchronizer before use; all timing below is relative to the synchronized signal.
REQ-016 Bit FSM SHALL have states OCIOSO, INICIO, DADOS, PARADA.
- OCIOSO: falling edge -> INICIO, bit counter cleared.
- INICIO: after CLKS_PER_BIT/2 cycles, sample; 0 -> DADOS; 1 -> OCIOSO (glitch, no erro).
- DADOS: sample every CLKS_PER_BIT cycles, shifting into bit 7 downward; after bit 7 -> PARADA.
- PARADA: sample after CLKS_PER_BIT cycles; 1 -> byte accepted; 0 -> erro pulse, byte dropped. Either way -> OCIOSO.
REQ-017 Bit-time counter SHALL be wide enough for CLKS_PER_BIT-1 and SHALL reload on every sample.
REQ-018 Word FSM SHALL have states ESPERA_ALTO, ESPERA_BAIXO: accepted byte in ESPERA_ALTO is stored -> ESPERA_BAIXO; accepted byte in ESPERA_BAIXO completes the word -> ESPERA_ALTO.
REQ-019 On word completion, all five field outputs SHALL update and valid SHALL pulse on the same edge, 1 cycle after the byte1 stop-bit sample.
REQ-020 Field outputs SHALL hold their last value between words; valid and erro SHALL never be high for more than one cycle.
REQ-021 A framing error in ESPERA_BAIXO SHALL discard the stored high byte and return the word FSM to ESPERA_ALTO.
REQ-022 A start edge arriving in the same cycle as the PARADA sample SHALL be ignored; detection resumes in OCIOSO on the next cycle.

Reset
REQ-023 While reset = 0: bit FSM = OCIOSO, word FSM = ESPERA_ALTO, synchronizer = 1, all field outputs = 0, valid = 0, erro = 0, counters = 0; reset mid-character SHALL abandon the character and any stored high byte.

Configuration
REQ-024 Macro JOGAO_RX_TIMEOUT_EN defined: in ESPERA_BAIXO, if no start edge occurs within TIMEOUT_BITS*CLKS_PER_BIT cycles after the byte0 stop sample, the high byte SHALL be discarded, erro SHALL pulse once, and the word FSM SHALL return to ESPERA_ALTO. Undefined: no timer; ESPERA_BAIXO waits indefinitely.

Verification (bench uses CLKS_PER_BIT=8, TIMEOUT_BITS=20)
REQ-025 Send bytes 0x5A, 0x3B -> one valid pulse; estado=5, macro=A, micro=3, resultado_macro=2, resultado_jogo=3; erro stays 0.
REQ-026 Send 0xFF with stop bit forced 0 -> one erro pulse, no valid; then 0x12, 0x34 -> valid with estado=1, macro=2, micro=3, resultado_macro=1, resultado_jogo=0.
REQ-027 Pulse s_in low for 2 cycles only -> no valid, no erro, FSM back in OCIOSO.
REQ-028 Send 0xC7, assert reset low mid-byte1, release, send 0x00, 0x0F -> outputs 0 during reset; then valid with estado=0, macro=0, micro=0, resultado_macro=3, resultado_jogo=3.
REQ-029 With JOGAO_RX_TIMEOUT_EN: send 0xAB, idle 200 cycles -> one erro pulse near cycle 160 after stop sample; then 0x81, 0x42 -> valid, estado=8, macro=1, micro=4, resultado_macro=0, resultado_jogo=2. Without the macro: same idle yields no erro; the next byte 0x81 completes word 0xAB81.
